sync_filter_bank: RTL and testbench
===================================

// Module: sync_filter_bank
// PURPOSE
//  Multi-channel synchronizer for asynchronous inputs such as buttons, serial lines and
//  status pins, feeding the clk domain. Each channel has four parts:
//  - a sync chain of configurable depth;
//  - a glitch/debounce filter that needs FILTER_LEN consecutive stable samples;
//  - registered rise pulses;
//  - registered fall pulses.
//  Generalises the fixed 2-flop single-bit synchronizer. Sits between pads/testbench
//  stimulus and edge-driven control FSMs.
// PARAMETERS
//  WIDTH       1    number of independent channels
//  STAGES      2    sync flops per channel; elaboration $error if < 2
//  FILTER_LEN  1    consecutive differing samples required before sync_out changes;
//                   $error if < 1; FILTER_LEN=1 means no filtering
//  RESET_VAL   '0   WIDTH-bit reset/idle level per channel; 1 for active-low idle-high
//                   lines such as UART RX
// PORTS
//  clk         in   1      system clock, all flops posedge
//  n_rst       in   1      reset: synchronous, active-high (1 = reset at next posedge clk)
//  async_in    in   WIDTH  asynchronous inputs
//  sync_raw    out  WIDTH  last sync stage, unfiltered (debug/fast path)
//  sync_out    out  WIDTH  filtered, synchronized level
//  rise_pulse  out  WIDTH  1-cycle pulse, sync_out 0->1
//  fall_pulse  out  WIDTH  1-cycle pulse, sync_out 1->0
// BEHAVIOUR
//  Reset
//  - Reset is synchronous: n_rst=1 sampled at posedge clk. Async_in has no effect during reset.
//  - All sync flops of channel i load RESET_VAL[i]. sync_raw = sync_out = RESET_VAL.
//  - Counters load 0. rise_pulse = fall_pulse = 0.
//  - Releasing reset never generates a pulse. Reset mid-filter discards the partial count.
//  Sync chain (per channel)
//  - s[0] <= async_in; s[k] <= s[k-1]; sync_raw = s[STAGES-1].
//  - Latency async_in -> sync_raw = STAGES edges.
//  Filter (per channel)
//  - cnt width = $clog2(FILTER_LEN+1).
//  - sync_raw == sync_out: cnt <= 0.
//  - Else, if cnt == FILTER_LEN-1: sync_out <= sync_raw and cnt <= 0.
//  - Else: cnt <= cnt + 1.
//  - A disagreement lasting < FILTER_LEN cycles leaves sync_out unchanged and clears cnt.
//    No pulse is generated.
//  - Total latency for a stable change async_in -> sync_out = STAGES + FILTER_LEN edges.
//  Edges
//  - rise_pulse <= update & sync_raw; fall_pulse <= update & ~sync_raw.
//  - update is the filter commit condition above.
//  - A pulse is high exactly in the first cycle sync_out shows the new level.
//  - rise and fall are never both high on one channel. Channels are fully independent.
//  Boundary cases
//  - Toggling every cycle with FILTER_LEN>=2: sync_out holds.
//  - Counter never exceeds FILTER_LEN-1 (no wrap).
// STRUCTURE
//  - Package sync_pkg:
//    - localparam MIN_STAGES = 2;
//    - function cnt_width(int len) returning $clog2(len+1);
//    - typedef enum {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_e for bench checkers.
//  - Sub-module sync_filter_cell: a single channel with parameters STAGES, FILTER_LEN,
//    RESET_BIT.
//  - Top: generate loop of WIDTH cells, plus elaboration-time parameter checks.
// TESTING
//  T1 WIDTH=1, STAGES=2, FILTER_LEN=1, async_in 0->1 at cycle 10
//     -> sync_raw=1 after 2 edges, sync_out=1 after 3, rise_pulse high exactly 1 cycle.
//  T2 STAGES=3, FILTER_LEN=4, 3-cycle high glitch
//     -> sync_out stays 0, no pulses; a 4-cycle high -> sync_out=1 at edge 3+4=7,
//        one rise_pulse.
//  T3 RESET_VAL=1, hold n_rst=1 while async_in=0, then release
//     -> outputs 1 during reset, no fall_pulse on release; fall occurs STAGES+FILTER_LEN
//        later.
//  T4 FILTER_LEN=4, assert n_rst for one cycle when cnt=2
//     -> cnt=0 and sync_out=RESET_VAL next cycle; the full 4 samples are needed again.
//  T5 WIDTH=4, channels driven with different patterns, including 0101 alternating each cycle
//     -> per-channel independence; alternating channel never changes.
//  T6 random async_in with no clk alignment, scoreboard model of chain+filter
//     -> exact match; rise&fall never simultaneous.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants, helpers and types for the synchronizer/filter bank.
package sync_pkg;

   localparam int MIN_STAGES = 2;

   function automatic int cnt_width(int len);
      return $clog2(len + 1);
   endfunction

   typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_e;

endpackage

// File: rtl/sync_filter_cell.sv
// One channel: sync chain, consecutive-sample debounce filter, registered edge pulses.
module sync_filter_cell
   import sync_pkg::*;
#(
   parameter int   STAGES     = 2,
   parameter int   FILTER_LEN = 1,
   parameter logic RESET_BIT  = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_raw,
   output logic sync_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CW = cnt_width(FILTER_LEN);
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

   logic [STAGES-1:0] r_chain;
   logic [CW-1:0]     r_cnt;
   logic              r_out;
   logic              r_rise;
   logic              r_fall;

   logic w_raw;
   logic w_differ;
   logic w_update;

   // NOTE: every flop, sync chain included, reloads the idle level so an idle-high
   // line does not produce a spurious fall as it comes out of reset.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_chain <= {STAGES{RESET_BIT}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], async_in};
      end
   end

   assign w_raw    = r_chain[STAGES-1];
   assign w_differ = (w_raw != r_out);
   assign w_update = w_differ && (r_cnt == LAST);

   // The counter saturates at LAST: reaching it commits the new level and clears it.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_out  <= RESET_BIT;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_update & w_raw;
         r_fall <= w_update & ~w_raw;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_update) begin
            r_out <= w_raw;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign sync_raw   = w_raw;
   assign sync_out   = r_out;
   assign rise_pulse = r_rise;
   assign fall_pulse = r_fall;

endmodule

// File: rtl/sync_filter_bank.sv
// WIDTH independent synchronizer/debounce channels with per-channel idle level.
module sync_filter_bank
   import sync_pkg::*;
#(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 2,
   parameter int               FILTER_LEN = 1,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_raw,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   generate
      if (STAGES < MIN_STAGES) begin : g_bad_stages
         $error("sync_filter_bank: STAGES=%0d is below the minimum of %0d", STAGES, MIN_STAGES);
      end
      if (FILTER_LEN < 1) begin : g_bad_filter
         $error("sync_filter_bank: FILTER_LEN=%0d must be at least 1", FILTER_LEN);
      end
   endgenerate

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sync_filter_cell #(
         .STAGES     (STAGES),
         .FILTER_LEN (FILTER_LEN),
         .RESET_BIT  (RESET_VAL[i])
      ) u_cell (
         .clk        (clk),
         .n_rst      (n_rst),
         .async_in   (async_in[i]),
         .sync_raw   (sync_raw[i]),
         .sync_out   (sync_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed checks of four bank configurations plus a randomized 4-channel run against a model.
module tb_sync_filter_bank;
   import sync_pkg::*;

   logic clk;
   int   total;
   int   bad;

   // u1: 1 ch, STAGES=2, FILTER_LEN=1
   logic rst1, a1, raw1, out1, rise1, fall1;
   // u2: 1 ch, STAGES=3, FILTER_LEN=4
   logic rst2, a2, raw2, out2, rise2, fall2;
   // u3: 1 ch, STAGES=2, FILTER_LEN=2, idle high
   logic rst3, a3, raw3, out3, rise3, fall3;
   // u5: 4 ch, STAGES=2, FILTER_LEN=2
   logic       rst5;
   logic [3:0] a5, raw5, out5, rise5, fall5;

   // model state for the randomized run on u5
   logic [3:0] m_s0, m_s1, m_out, m_rise, m_fall;
   int         m_cnt [4];

   sync_filter_bank #(.WIDTH(1), .STAGES(2), .FILTER_LEN(1), .RESET_VAL(1'b0)) u1 (
      .clk(clk), .n_rst(rst1), .async_in(a1),
      .sync_raw(raw1), .sync_out(out1), .rise_pulse(rise1), .fall_pulse(fall1));

   sync_filter_bank #(.WIDTH(1), .STAGES(3), .FILTER_LEN(4), .RESET_VAL(1'b0)) u2 (
      .clk(clk), .n_rst(rst2), .async_in(a2),
      .sync_raw(raw2), .sync_out(out2), .rise_pulse(rise2), .fall_pulse(fall2));

   sync_filter_bank #(.WIDTH(1), .STAGES(2), .FILTER_LEN(2), .RESET_VAL(1'b1)) u3 (
      .clk(clk), .n_rst(rst3), .async_in(a3),
      .sync_raw(raw3), .sync_out(out3), .rise_pulse(rise3), .fall_pulse(fall3));

   sync_filter_bank #(.WIDTH(4), .STAGES(2), .FILTER_LEN(2), .RESET_VAL(4'b0000)) u5 (
      .clk(clk), .n_rst(rst5), .async_in(a5),
      .sync_raw(raw5), .sync_out(out5), .rise_pulse(rise5), .fall_pulse(fall5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_edge(input string tag, input logic r, input logic f, input edge_e e);
      check(tag, {6'b0, r, f}, {6'b0, e == EDGE_RISE, e == EDGE_FALL});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; rst5 = 1'b1;
      a1 = 1'b0; a2 = 1'b0; a3 = 1'b0; a5 = 4'b0000;
      tick();
      tick();

      // reset state
      check("rst_u1_raw", {7'b0, raw1}, 8'd0);
      check("rst_u1_out", {7'b0, out1}, 8'd0);
      check_edge("rst_u1_edge", rise1, fall1, EDGE_NONE);
      check("rst_u3_raw", {7'b0, raw3}, 8'd1);
      check("rst_u3_out", {7'b0, out3}, 8'd1);
      check("rst_u5_out", {4'b0, out5}, 8'd0);
      rst1 = 1'b0; rst2 = 1'b0; rst5 = 1'b0;

      // T1: 0->1 around cycle 10, raw after 2 edges, out after 3, one rise
      repeat (8) tick();
      check("t1_idle_out", {7'b0, out1}, 8'd0);
      a1 = 1'b1;
      tick();
      check("t1_e1_raw", {7'b0, raw1}, 8'd0);
      tick();
      check("t1_e2_raw", {7'b0, raw1}, 8'd1);
      check("t1_e2_out", {7'b0, out1}, 8'd0);
      tick();
      check("t1_e3_out", {7'b0, out1}, 8'd1);
      check_edge("t1_e3_edge", rise1, fall1, EDGE_RISE);
      tick();
      check("t1_e4_out", {7'b0, out1}, 8'd1);
      check_edge("t1_e4_edge", rise1, fall1, EDGE_NONE);

      // u3 held in reset with async_in=0 must stay at its idle level
      check("t3_hold_out", {7'b0, out3}, 8'd1);
      check_edge("t3_hold_edge", rise3, fall3, EDGE_NONE);

      // T2: 3-cycle glitch is rejected by FILTER_LEN=4
      a2 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 3) a2 = 1'b0;
         check($sformatf("t2_glitch_out_k%0d", k), {7'b0, out2}, 8'd0);
         check_edge($sformatf("t2_glitch_edge_k%0d", k), rise2, fall2, EDGE_NONE);
      end

      // T2: 4-cycle high commits at edge 7, low commits 4 edges after raw falls
      a2 = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 4) a2 = 1'b0;
         check($sformatf("t2_pulse_raw_k%0d", k), {7'b0, raw2}, {7'b0, (k >= 3 && k <= 6)});
         check($sformatf("t2_pulse_out_k%0d", k), {7'b0, out2}, {7'b0, (k >= 7 && k <= 10)});
         check_edge($sformatf("t2_pulse_edge_k%0d", k), rise2, fall2,
                    (k == 7) ? EDGE_RISE : (k == 11) ? EDGE_FALL : EDGE_NONE);
      end

      // T4: reset with the count at 2 discards progress
      a2 = 1'b1;
      repeat (5) tick();
      check("t4_pre_out", {7'b0, out2}, 8'd0);
      rst2 = 1'b1;
      tick();
      check("t4_rst_out", {7'b0, out2}, 8'd0);
      check("t4_rst_raw", {7'b0, raw2}, 8'd0);
      rst2 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("t4_out_k%0d", k), {7'b0, out2}, {7'b0, (k >= 7)});
         check_edge($sformatf("t4_edge_k%0d", k), rise2, fall2,
                    (k == 7) ? EDGE_RISE : EDGE_NONE);
      end

      // T3: idle-high release with input low, no pulse on release, fall at STAGES+FILTER_LEN
      rst3 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("t3_raw_k%0d", k), {7'b0, raw3}, {7'b0, (k < 2)});
         check($sformatf("t3_out_k%0d", k), {7'b0, out3}, {7'b0, (k < 4)});
         check_edge($sformatf("t3_edge_k%0d", k), rise3, fall3,
                    (k == 4) ? EDGE_FALL : EDGE_NONE);
      end

      // T5: ch0 steady high, ch1 alternating, ch2 low, ch3 single-cycle glitch
      a5 = 4'b1011;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("t5_out_k%0d", k), {4'b0, out5}, (k >= 4) ? 8'h01 : 8'h00);
         check($sformatf("t5_rise_k%0d", k), {4'b0, rise5}, (k == 4) ? 8'h01 : 8'h00);
         check($sformatf("t5_fall_k%0d", k), {4'b0, fall5}, 8'h00);
         if (k >= 2)
            check($sformatf("t5_raw1_k%0d", k), {7'b0, raw5[1]}, {7'b0, ((k - 1) % 2 == 1)});
         a5[1] = ~a5[1];
         if (k == 1) a5[3] = 1'b0;
      end

      // T6: unaligned random input against a model of chain + filter
      a5   = 4'b0000;
      rst5 = 1'b1;
      tick();
      rst5 = 1'b0;
      m_s0 = '0; m_s1 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      for (int n = 0; n < 150; n++) begin
         #($urandom_range(0, 7));
         a5 = a5 ^ (4'($urandom) & 4'($urandom));
         @(posedge clk);
         #1;
         for (int c = 0; c < 4; c++) begin
            logic raw_old, differ, upd;
            raw_old   = m_s1[c];
            differ    = (raw_old != m_out[c]);
            upd       = differ && (m_cnt[c] == 1);
            m_rise[c] = upd & raw_old;
            m_fall[c] = upd & ~raw_old;
            if (!differ) begin
               m_cnt[c] = 0;
            end else if (upd) begin
               m_out[c] = raw_old;
               m_cnt[c] = 0;
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
         end
         m_s1 = m_s0;
         m_s0 = a5;
         check($sformatf("t6_raw_n%0d", n), {4'b0, raw5}, {4'b0, m_s1});
         check($sformatf("t6_out_n%0d", n), {4'b0, out5}, {4'b0, m_out});
         check($sformatf("t6_rise_n%0d", n), {4'b0, rise5}, {4'b0, m_rise});
         check($sformatf("t6_fall_n%0d", n), {4'b0, fall5}, {4'b0, m_fall});
         check($sformatf("t6_excl_n%0d", n), {4'b0, rise5 & fall5}, 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
